// File: rtl/placement_pkg.sv
// Shared definitions for the placement cost evaluator: FSM state encoding and
// the rounding-up halving helper used for the 1-hop cost.
package placement_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_EDGE = 3'd1,
        RD_A    = 3'd2,
        RD_B    = 3'd3,
        DIFF    = 3'd4,
        ACC     = 3'd5,
        FIN     = 3'd6
    } state_t;

    localparam int HALF_W = 64;

    // ceil(d/2) for a non-negative magnitude; callers cast to their own width.
    function automatic logic [HALF_W-1:0] ceil_half(input logic [HALF_W-1:0] d);
        return (d >> 1) + {{(HALF_W-1){1'b0}}, d[0]};
    endfunction

endpackage

// File: rtl/abs_diff.sv
// Signed absolute difference |a-b|, wrapping at W bits.
module abs_diff #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic        [W-1:0] o_y
);

    logic signed [W-1:0] w_diff;

    assign w_diff = i_a - i_b;
    assign o_y    = w_diff[W-1] ? -w_diff : w_diff;

endmodule

// File: rtl/placement_cost_eval.sv
// Walks the edge list, fetches both endpoint coordinates from the position RAMs
// and accumulates Manhattan / 1-hop wire cost, stopping on the first illegal edge.
module placement_cost_eval
    import placement_pkg::*;
#(
    parameter int N_EDGE = 22,
    parameter int GRID_N = 5,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     ea_re,
    output logic                     eb_re,
    output logic [ADDR_W-1:0]        ea_addr,
    output logic [ADDR_W-1:0]        eb_addr,
    input  logic [DATA_W-1:0]        ea_data,
    input  logic [DATA_W-1:0]        eb_data,
    output logic                     px_re,
    output logic                     py_re,
    output logic [ADDR_W-1:0]        px_addr,
    output logic [ADDR_W-1:0]        py_addr,
    input  logic signed [DATA_W-1:0] px_data,
    input  logic signed [DATA_W-1:0] py_data,
    output logic signed [DATA_W-1:0] sum,
    output logic signed [DATA_W-1:0] sum_1hop,
    output logic signed [DATA_W-1:0] max_len,
    output logic                     err,
    output logic [ADDR_W-1:0]        err_edge,
    output logic [DATA_W-1:0]        cycles
);

    localparam logic [ADDR_W-1:0]        N_LIM    = ADDR_W'(N_EDGE);
    localparam logic signed [DATA_W-1:0] GRID_LIM = DATA_W'(GRID_N);
    localparam logic signed [DATA_W-1:0] ONE      = DATA_W'(1);

    state_t                     r_state;
    state_t                     w_next;
    logic [ADDR_W-1:0]          r_i;
    logic [ADDR_W-1:0]          r_node_b;
    logic signed [DATA_W-1:0]   r_xa;
    logic signed [DATA_W-1:0]   r_ya;
    logic [DATA_W-1:0]          r_dx;
    logic [DATA_W-1:0]          r_dy;
    logic [DATA_W-1:0]          w_dx;
    logic [DATA_W-1:0]          w_dy;
    logic [DATA_W-1:0]          w_len;
    logic [DATA_W-1:0]          w_hop;
    logic                       w_bad;
    logic                       r_busy;
    logic                       r_done;
    logic signed [DATA_W-1:0]   r_sum;
    logic signed [DATA_W-1:0]   r_sum_1hop;
    logic signed [DATA_W-1:0]   r_max_len;
    logic                       r_err;
    logic [ADDR_W-1:0]          r_err_edge;
    logic [DATA_W-1:0]          r_cycles;

    function automatic logic off_grid(input logic signed [DATA_W-1:0] c);
        return c[DATA_W-1] | (c >= GRID_LIM);
    endfunction

    // In DIFF the second endpoint is still on the RAM data bus, so compare it directly.
    abs_diff #(.W(DATA_W)) u_abs_x (.i_a(r_xa), .i_b(px_data), .o_y(w_dx));
    abs_diff #(.W(DATA_W)) u_abs_y (.i_a(r_ya), .i_b(py_data), .o_y(w_dy));

    assign w_bad = off_grid(r_xa) | off_grid(r_ya) | off_grid(px_data) | off_grid(py_data);
    assign w_len = r_dx + r_dy;
    assign w_hop = DATA_W'(ceil_half(HALF_W'(r_dx))) + DATA_W'(ceil_half(HALF_W'(r_dy)));

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next = RD_EDGE;
                else       w_next = IDLE;
            end
            RD_EDGE: begin
                if (r_i == N_LIM) w_next = FIN;
                else              w_next = RD_A;
            end
            RD_A:    w_next = RD_B;
            RD_B:    w_next = DIFF;
            DIFF: begin
                if (w_bad) w_next = FIN;
                else       w_next = ACC;
            end
            ACC:     w_next = RD_EDGE;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Memory read strobes; node a's address comes straight off the edge ROM bus.
    always_comb begin
        ea_re   = 1'b0;
        ea_addr = '0;
        px_re   = 1'b0;
        px_addr = '0;
        case (r_state)
            RD_EDGE: begin
                if (r_i != N_LIM) begin
                    ea_re   = 1'b1;
                    ea_addr = r_i;
                end else begin
                    ea_re   = 1'b0;
                    ea_addr = '0;
                end
            end
            RD_A: begin
                px_re   = 1'b1;
                px_addr = ADDR_W'(ea_data);
            end
            RD_B: begin
                px_re   = 1'b1;
                px_addr = r_node_b;
            end
            default: begin
                ea_re   = 1'b0;
                px_re   = 1'b0;
            end
        endcase
    end

    assign eb_re   = ea_re;
    assign eb_addr = ea_addr;
    assign py_re   = px_re;
    assign py_addr = px_addr;

    // State, datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_i        <= '0;
            r_node_b   <= '0;
            r_xa       <= '0;
            r_ya       <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_sum      <= '0;
            r_sum_1hop <= '0;
            r_max_len  <= '0;
            r_err      <= 1'b0;
            r_err_edge <= '0;
            r_cycles   <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == FIN);
            // cycles reads as the number of busy cycles so far, including the current one.
            if (r_state != IDLE && w_next != IDLE) r_cycles <= r_cycles + ONE;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_i        <= '0;
                        r_sum      <= '0;
                        r_sum_1hop <= '0;
                        r_max_len  <= '0;
                        r_err      <= 1'b0;
                        r_err_edge <= '0;
                        r_cycles   <= ONE;
                    end
                end
                RD_A: r_node_b <= ADDR_W'(eb_data);
                RD_B: begin
                    r_xa <= px_data;
                    r_ya <= py_data;
                end
                DIFF: begin
                    r_dx <= w_dx;
                    r_dy <= w_dy;
                    if (w_bad) begin
                        r_err      <= 1'b1;
                        r_err_edge <= r_i;
                    end
                end
                ACC: begin
                    r_sum      <= r_sum + $signed(w_len) - ONE;
                    r_sum_1hop <= r_sum_1hop + $signed(w_hop) - ONE;
                    if ($signed(w_len) > r_max_len) r_max_len <= $signed(w_len);
                    r_i        <= r_i + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign sum_1hop = r_sum_1hop;
    assign max_len  = r_max_len;
    assign err      = r_err;
    assign err_edge = r_err_edge;
    assign cycles   = r_cycles;

endmodule

// File: tb/tb_placement_cost_eval.sv
// Drives four evaluator instances (0, 1, 2 and 6 edges) from shared edge/position
// memories and checks them every cycle against an edge-list cost model.
module tb_placement_cost_eval;

    localparam int NI        = 4;
    localparam int NS [NI]   = '{0, 1, 2, 6};
    localparam int GRID      = 5;

    typedef struct packed {
        int sum;
        int hop;
        int mx;
        int err;
        int eedge;
        int ncyc;
    } res_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy_o [NI];
    logic        done_o [NI];
    logic        ea_re  [NI];
    logic        eb_re  [NI];
    logic        px_re  [NI];
    logic        py_re  [NI];
    logic        err_o  [NI];
    logic [31:0] ea_addr[NI];
    logic [31:0] eb_addr[NI];
    logic [31:0] px_addr[NI];
    logic [31:0] py_addr[NI];
    logic [31:0] ea_d   [NI];
    logic [31:0] eb_d   [NI];
    logic [31:0] px_d   [NI];
    logic [31:0] py_d   [NI];
    logic [31:0] sum_o  [NI];
    logic [31:0] hop_o  [NI];
    logic [31:0] max_o  [NI];
    logic [31:0] eedge_o[NI];
    logic [31:0] cyc_o  [NI];

    int   ea_rom [8];
    int   eb_rom [8];
    int   px_m   [8];
    int   py_m   [8];

    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   t0     [NI];
    bit   active [NI];
    bit   armed  [NI];
    res_t exp_r  [NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_inst
        placement_cost_eval #(
            .N_EDGE(NS[k]), .GRID_N(GRID), .ADDR_W(32), .DATA_W(32)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start),
            .busy(busy_o[k]), .done(done_o[k]),
            .ea_re(ea_re[k]), .eb_re(eb_re[k]),
            .ea_addr(ea_addr[k]), .eb_addr(eb_addr[k]),
            .ea_data(ea_d[k]), .eb_data(eb_d[k]),
            .px_re(px_re[k]), .py_re(py_re[k]),
            .px_addr(px_addr[k]), .py_addr(py_addr[k]),
            .px_data(px_d[k]), .py_data(py_d[k]),
            .sum(sum_o[k]), .sum_1hop(hop_o[k]), .max_len(max_o[k]),
            .err(err_o[k]), .err_edge(eedge_o[k]), .cycles(cyc_o[k])
        );
    end

    // One-cycle-latency ROM/RAM models
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (ea_re[k]) ea_d[k] <= ea_rom[ea_addr[k][2:0]];
            if (eb_re[k]) eb_d[k] <= eb_rom[eb_addr[k][2:0]];
            if (px_re[k]) px_d[k] <= px_m[px_addr[k][2:0]];
            if (py_re[k]) py_d[k] <= py_m[py_addr[k][2:0]];
        end
    end

    function automatic bit off(input int c);
        return (c < 0) || (c >= GRID);
    endfunction

    // Cost of the placement over the first n edges, straight from the edge list
    function automatic res_t model(input int n);
        res_t r;
        int a, b, dx, dy;
        r = '0;
        r.ncyc = 5 * n + 2;
        for (int e = 0; e < n; e++) begin
            a = ea_rom[e];
            b = eb_rom[e];
            if (off(px_m[a]) || off(py_m[a]) || off(px_m[b]) || off(py_m[b])) begin
                r.err   = 1;
                r.eedge = e;
                r.ncyc  = 5 * e + 5;
                return r;
            end
            dx = (px_m[a] > px_m[b]) ? px_m[a] - px_m[b] : px_m[b] - px_m[a];
            dy = (py_m[a] > py_m[b]) ? py_m[a] - py_m[b] : py_m[b] - py_m[a];
            r.sum = r.sum + dx + dy - 1;
            r.hop = r.hop + (dx + 1) / 2 + (dy + 1) / 2 - 1;
            if (dx + dy > r.mx) r.mx = dx + dy;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input int k, input int got, input int expv);
        n_vec++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s u%0d: got %0d, expected %0d (cycle %0d)", nm, k, got, expv, cyc);
        end
    endtask

    // Model update: reset and accepted starts seen on the same edge as the DUT
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                armed[k]  <= 1'b1;
                active[k] <= 1'b0;
                exp_r[k]  <= '0;
            end else if (start && (!active[k] || cyc > t0[k] + exp_r[k].ncyc)) begin
                active[k] <= 1'b1;
                t0[k]     <= cyc;
                exp_r[k]  <= model(NS[k]);
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin : cmp
        int rel;
        bit in_win;
        bit at_done;
        for (int k = 0; k < NI; k++) begin
            if (armed[k]) begin
                rel     = cyc - t0[k];
                in_win  = active[k] && rel >= 1 && rel <= exp_r[k].ncyc;
                at_done = active[k] && rel == exp_r[k].ncyc;
                chk("busy", k, int'(busy_o[k]), int'(in_win));
                chk("done", k, int'(done_o[k]), int'(at_done));
                if (!in_win || at_done) begin
                    chk("sum",      k, int'(sum_o[k]),   exp_r[k].sum);
                    chk("sum_1hop", k, int'(hop_o[k]),   exp_r[k].hop);
                    chk("max_len",  k, int'(max_o[k]),   exp_r[k].mx);
                    chk("err",      k, int'(err_o[k]),   exp_r[k].err);
                    chk("err_edge", k, int'(eedge_o[k]), exp_r[k].eedge);
                    chk("cycles",   k, int'(cyc_o[k]),   exp_r[k].ncyc);
                end
            end
        end
    end

    task automatic clear_tables();
        for (int j = 0; j < 8; j++) begin
            ea_rom[j] = 0;
            eb_rom[j] = 1;
            px_m[j]   = 0;
            py_m[j]   = 0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int rnd_coord();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 3)      return -1;
        else if (r < 5) return GRID;
        else            return int'($urandom_range(0, GRID - 1));
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear_tables();
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(1);
        chk("rst_busy", 3, int'(busy_o[3]), 0);
        chk("rst_sum",  3, int'(sum_o[3]), 0);

        // One edge: node0 (0,0) to node1 (3,1)
        ea_rom[0] = 0; eb_rom[0] = 1;
        px_m[1] = 3;   py_m[1] = 1;
        pulse_start();
        wait_cycles(40);
        chk("lit_one_sum",    1, int'(sum_o[1]), 3);
        chk("lit_one_hop",    1, int'(hop_o[1]), 2);
        chk("lit_one_max",    1, int'(max_o[1]), 4);
        chk("lit_one_err",    1, int'(err_o[1]), 0);
        chk("lit_one_cycles", 1, int'(cyc_o[1]), 7);
        chk("lit_zero_cyc",   0, int'(cyc_o[0]), 2);
        chk("lit_zero_sum",   0, int'(sum_o[0]), 0);

        // Reset on the third busy cycle aborts, then a fresh run is clean
        pulse_start();
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        chk("abort_busy", 3, int'(busy_o[3]), 0);
        chk("abort_sum",  1, int'(sum_o[1]), 0);
        pulse_start();
        wait_cycles(40);
        chk("rerun_sum",  1, int'(sum_o[1]), 3);

        // Two edges (0,0)-(1,0) and (2,2)-(4,4), with a start repeated mid-run
        clear_tables();
        ea_rom[0] = 2; eb_rom[0] = 3;
        ea_rom[1] = 4; eb_rom[1] = 5;
        px_m[3] = 1;
        px_m[4] = 2; py_m[4] = 2;
        px_m[5] = 4; py_m[5] = 4;
        pulse_start();
        wait_cycles(3);
        start = 1'b1;
        wait_cycles(1);
        start = 1'b0;
        wait_cycles(40);
        chk("lit_two_sum",    2, int'(sum_o[2]), 3);
        chk("lit_two_hop",    2, int'(hop_o[2]), 1);
        chk("lit_two_max",    2, int'(max_o[2]), 4);
        chk("lit_two_cycles", 2, int'(cyc_o[2]), 12);

        // Second edge's node b unplaced
        px_m[5] = -1; py_m[5] = -1;
        pulse_start();
        wait_cycles(40);
        chk("lit_unpl_err",   2, int'(err_o[2]), 1);
        chk("lit_unpl_edge",  2, int'(eedge_o[2]), 1);
        chk("lit_unpl_sum",   2, int'(sum_o[2]), 0);
        chk("lit_unpl_cyc",   2, int'(cyc_o[2]), 10);

        // Coordinate equal to the grid size on edge 0
        clear_tables();
        px_m[1] = GRID;
        pulse_start();
        wait_cycles(40);
        chk("lit_edge_err",   1, int'(err_o[1]), 1);
        chk("lit_edge_idx",   1, int'(eedge_o[1]), 0);
        chk("lit_edge_cyc",   1, int'(cyc_o[1]), 5);

        // Random placements, stray starts and occasional resets
        for (int r = 0; r < 60; r++) begin
            for (int j = 0; j < 8; j++) begin
                ea_rom[j] = int'($urandom_range(0, 7));
                eb_rom[j] = int'($urandom_range(0, 7));
                px_m[j]   = rnd_coord();
                py_m[j]   = rnd_coord();
            end
            pulse_start();
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                start = ($urandom_range(0, 9) == 0);
                reset = ($urandom_range(0, 199) == 0);
            end
            @(negedge clk);
            start = 1'b0;
            reset = 1'b0;
            wait_cycles(40);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
